// File: rtl/captura_numeros.sv
// Assembles two decimal operands from keypad strobes, keeping each in BCD and
// binary form, and hands them downstream through a done/ack handshake.
module captura_numeros #(
  parameter int unsigned N_DIGITS = 3,
  parameter int unsigned BIN_W    = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    key_valid,
  input  logic [3:0]              key_code,
  input  logic                    ack,
  output logic [4*N_DIGITS-1:0]   numero1_bcd,
  output logic [4*N_DIGITS-1:0]   numero2_bcd,
  output logic [BIN_W-1:0]        numero1_bin,
  output logic [BIN_W-1:0]        numero2_bin,
  output logic [1:0]              digit_count,
  output logic                    sel_num2,
  output logic                    done
);

  localparam int unsigned BCD_W   = 4 * N_DIGITS;
  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hB;
  localparam logic [BIN_W-1:0] TEN = BIN_W'(10);

  typedef enum logic [1:0] {
    S_NUM1 = 2'd0,
    S_NUM2 = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [BCD_W-1:0]   n1_bcd_q, n1_bcd_d, n2_bcd_q, n2_bcd_d;
  logic [BIN_W-1:0]   n1_bin_q, n1_bin_d, n2_bin_q, n2_bin_d;
  logic [1:0]         cnt_q, cnt_d;
  logic               sel_q, sel_d;
  logic               done_q, done_d;

  logic               key_digit;
  logic               room;
  logic               clear_all;

  // Next-state and operand update
  always_comb begin
    state_d   = state_q;
    n1_bcd_d  = n1_bcd_q;
    n2_bcd_d  = n2_bcd_q;
    n1_bin_d  = n1_bin_q;
    n2_bin_d  = n2_bin_q;
    cnt_d     = cnt_q;
    clear_all = 1'b0;
    key_digit = key_valid && (key_code <= 4'd9);
    room      = 32'(cnt_q) < N_DIGITS;

    case (state_q)
      S_NUM1, S_NUM2: begin
        if (key_valid && key_code == KEY_CLEAR) begin
          clear_all = 1'b1;
        end else if (key_valid && key_code == KEY_ENTER) begin
          if (state_q == S_NUM1) begin
            state_d = S_NUM2;
            cnt_d   = 2'd0;
          end else begin
            state_d = S_DONE;
          end
        end else if (key_digit && room) begin
          if (state_q == S_NUM1) begin
            n1_bcd_d = {n1_bcd_q[BCD_W-5:0], key_code};
            n1_bin_d = n1_bin_q * TEN + BIN_W'(key_code);
          end else begin
            n2_bcd_d = {n2_bcd_q[BCD_W-5:0], key_code};
            n2_bin_d = n2_bin_q * TEN + BIN_W'(key_code);
          end
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_DONE: begin
        // Operands are frozen here; only ack or clear release them.
        if (ack || (key_valid && key_code == KEY_CLEAR)) begin
          clear_all = 1'b1;
        end
      end
      default: clear_all = 1'b1;
    endcase

    if (clear_all) begin
      state_d  = S_NUM1;
      n1_bcd_d = '0;
      n2_bcd_d = '0;
      n1_bin_d = '0;
      n2_bin_d = '0;
      cnt_d    = 2'd0;
    end

    sel_d  = (state_d != S_NUM1);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_NUM1;
      n1_bcd_q <= '0;
      n2_bcd_q <= '0;
      n1_bin_q <= '0;
      n2_bin_q <= '0;
      cnt_q    <= 2'd0;
      sel_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      n1_bcd_q <= n1_bcd_d;
      n2_bcd_q <= n2_bcd_d;
      n1_bin_q <= n1_bin_d;
      n2_bin_q <= n2_bin_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      done_q   <= done_d;
    end
  end

  assign numero1_bcd = n1_bcd_q;
  assign numero2_bcd = n2_bcd_q;
  assign numero1_bin = n1_bin_q;
  assign numero2_bin = n2_bin_q;
  assign digit_count = cnt_q;
  assign sel_num2    = sel_q;
  assign done        = done_q;

endmodule

// File: tb/tb_captura_numeros.sv
// Bench for captura_numeros: directed scenarios plus random keys checked
// against a digit-list model of the two operands.
module tb_captura_numeros;

  logic        clk;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        ack;
  logic [11:0] numero1_bcd, numero2_bcd;
  logic [9:0]  numero1_bin, numero2_bin;
  logic [1:0]  digit_count;
  logic        sel_num2, done;

  int errors = 0;
  int checks = 0;

  // Model: digits typed so far per operand, and phase 0/1/2 (entering 1, entering 2, done)
  int m_q1[$];
  int m_q2[$];
  int m_phase;

  captura_numeros #(.N_DIGITS(3), .BIN_W(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .ack         (ack),
    .numero1_bcd (numero1_bcd),
    .numero2_bcd (numero2_bcd),
    .numero1_bin (numero1_bin),
    .numero2_bin (numero2_bin),
    .digit_count (digit_count),
    .sel_num2    (sel_num2),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    m_q1.delete();
    m_q2.delete();
    m_phase = 0;
  endfunction

  function automatic void model_apply(input logic v, input logic [3:0] c, input logic a);
    int code;
    code = int'(c);
    if (m_phase == 2 && a) begin
      model_reset();
    end else if (v) begin
      if (code == 11) model_reset();
      else if (code <= 9 && m_phase == 0 && m_q1.size() < 3) m_q1.push_back(code);
      else if (code <= 9 && m_phase == 1 && m_q2.size() < 3) m_q2.push_back(code);
      else if (code == 10 && m_phase < 2) m_phase = m_phase + 1;
    end
  endfunction

  function automatic logic [11:0] digits_bcd(input int q[$]);
    logic [11:0] r;
    r = '0;
    foreach (q[i]) r = r + 12'(q[q.size()-1-i] << (4*i));
    return r;
  endfunction

  function automatic logic [9:0] digits_bin(input int q[$]);
    int v;
    v = 0;
    foreach (q[i]) v = v * 10 + q[i];
    return 10'(v);
  endfunction

  function automatic logic [47:0] model_vec();
    int cnt;
    cnt = (m_phase == 0) ? m_q1.size() : m_q2.size();
    return {digits_bcd(m_q1), digits_bcd(m_q2), digits_bin(m_q1), digits_bin(m_q2),
            2'(cnt), m_phase != 0, m_phase == 2};
  endfunction

  // Present one cycle of inputs, wait past the edge, update the model.
  task automatic step(input logic v, input logic [3:0] c, input logic a);
    key_valid = v;
    key_code  = c;
    ack       = a;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'h0;
    ack       = 1'b0;
    model_apply(v, c, a);
  endtask

  task automatic key(input logic [3:0] c);
    step(1'b1, c, 1'b0);
  endtask

  task automatic test_reset();
    logic [47:0] obs;
    obs = {numero1_bcd, numero2_bcd, numero1_bin, numero2_bin, digit_count, sel_num2, done};
    checks++;
    if (obs !== 48'h0) begin
      errors++;
      $display("FAIL reset_initial got=%h exp=0", obs);
    end
    key(4'd4);
    key(4'd5);
    checks++;
    if (numero1_bcd !== 12'h045 || digit_count !== 2'd2) begin
      errors++;
      $display("FAIL reset_preload bcd=%h cnt=%0d exp bcd=045 cnt=2", numero1_bcd, digit_count);
    end
    #2 rst = 1'b1;
    #1;
    obs = {numero1_bcd, numero2_bcd, numero1_bin, numero2_bin, digit_count, sel_num2, done};
    checks++;
    if (obs !== 48'h0) begin
      errors++;
      $display("FAIL reset_async got=%h exp=0", obs);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    checks++;
    if (numero1_bcd !== 12'h0 || sel_num2 !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_release bcd=%h sel=%b done=%b exp 0", numero1_bcd, sel_num2, done);
    end
  endtask

  task automatic test_full_entry();
    key(4'd1); key(4'd2); key(4'd3); key(4'hA); key(4'd4); key(4'd5);
    checks++;
    if (done !== 1'b0 || sel_num2 !== 1'b1 || digit_count !== 2'd2) begin
      errors++;
      $display("FAIL full_pre_enter done=%b sel=%b cnt=%0d exp 0 1 2", done, sel_num2, digit_count);
    end
    key(4'hA);
    checks++;
    if (numero1_bcd !== 12'h123 || numero1_bin !== 10'd123) begin
      errors++;
      $display("FAIL full_num1 bcd=%h bin=%0d exp 123 123", numero1_bcd, numero1_bin);
    end
    checks++;
    if (numero2_bcd !== 12'h045 || numero2_bin !== 10'd45) begin
      errors++;
      $display("FAIL full_num2 bcd=%h bin=%0d exp 045 45", numero2_bcd, numero2_bin);
    end
    checks++;
    if (done !== 1'b1 || sel_num2 !== 1'b1) begin
      errors++;
      $display("FAIL full_done done=%b sel=%b exp 1 1", done, sel_num2);
    end
  endtask

  task automatic test_handshake();
    key(4'd5);
    key(4'hA);
    key(4'hF);
    checks++;
    if (numero1_bcd !== 12'h123 || numero2_bcd !== 12'h045 || numero2_bin !== 10'd45 || done !== 1'b1) begin
      errors++;
      $display("FAIL hs_hold n1=%h n2=%h b2=%0d done=%b exp 123 045 45 1",
               numero1_bcd, numero2_bcd, numero2_bin, done);
    end
    step(1'b1, 4'd3, 1'b1);
    checks++;
    if ({numero1_bcd, numero2_bcd, numero1_bin, numero2_bin, digit_count, sel_num2, done} !== 48'h0) begin
      errors++;
      $display("FAIL hs_ack n1=%h n2=%h cnt=%0d sel=%b done=%b exp all 0",
               numero1_bcd, numero2_bcd, digit_count, sel_num2, done);
    end
  endtask

  task automatic test_overflow();
    key(4'd9); key(4'd9); key(4'd9); key(4'd7);
    checks++;
    if (numero1_bcd !== 12'h999 || numero1_bin !== 10'd999 || digit_count !== 2'd3) begin
      errors++;
      $display("FAIL overflow bcd=%h bin=%0d cnt=%0d exp 999 999 3", numero1_bcd, numero1_bin, digit_count);
    end
    step(1'b0, 4'h0, 1'b1);
    checks++;
    if (numero1_bcd !== 12'h999 || sel_num2 !== 1'b0) begin
      errors++;
      $display("FAIL ack_outside_done bcd=%h sel=%b exp 999 0", numero1_bcd, sel_num2);
    end
    key(4'hB);
  endtask

  task automatic test_empty_operand();
    key(4'hA);
    key(4'd8);
    key(4'hA);
    checks++;
    if (numero1_bcd !== 12'h0 || numero1_bin !== 10'd0 || numero2_bcd !== 12'h008 ||
        numero2_bin !== 10'd8 || done !== 1'b1) begin
      errors++;
      $display("FAIL empty n1=%h b1=%0d n2=%h b2=%0d done=%b exp 0 0 008 8 1",
               numero1_bcd, numero1_bin, numero2_bcd, numero2_bin, done);
    end
    key(4'hB);
    checks++;
    if (done !== 1'b0 || numero2_bcd !== 12'h0 || sel_num2 !== 1'b0) begin
      errors++;
      $display("FAIL clear_in_done done=%b n2=%h sel=%b exp 0 0 0", done, numero2_bcd, sel_num2);
    end
  endtask

  task automatic test_clear_junk();
    key(4'd6);
    repeat (4) @(negedge clk);
    key(4'hE);
    checks++;
    if (numero1_bcd !== 12'h006 || numero1_bin !== 10'd6 || digit_count !== 2'd1) begin
      errors++;
      $display("FAIL junk_ignored bcd=%h bin=%0d cnt=%0d exp 006 6 1", numero1_bcd, numero1_bin, digit_count);
    end
    repeat (3) @(negedge clk);
    key(4'hB);
    checks++;
    if ({numero1_bcd, numero2_bcd, numero1_bin, numero2_bin, digit_count, sel_num2, done} !== 48'h0) begin
      errors++;
      $display("FAIL clear_all n1=%h b1=%0d cnt=%0d exp all 0", numero1_bcd, numero1_bin, digit_count);
    end
  endtask

  task automatic test_random();
    logic        v, a;
    logic [3:0]  c;
    logic [47:0] obs, exp_v;
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      a = ($urandom_range(0, 4) == 0);
      step(v, c, a);
      obs   = {numero1_bcd, numero2_bcd, numero1_bin, numero2_bin, digit_count, sel_num2, done};
      exp_v = model_vec();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL random_%0d got=%h exp=%h", i, obs, exp_v);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'h0;
    ack       = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_full_entry();
    test_handshake();
    test_overflow();
    test_empty_operand();
    test_clear_junk();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/captura_numeros.md
Name: captura_numeros

Overview:
- Downstream consumer of the keypad-reading stage. That stage emits one-cycle key strobes with a 4-bit key code.
- This block assembles two decimal operands of up to N_DIGITS digits each. It holds each operand in both BCD and binary form.
- It raises done once both operands are entered. The done/ack handshake hands the operands to the arithmetic/display stage.

Parameters:
- N_DIGITS, 3: maximum decimal digits per operand.
- BIN_W, 10: binary operand width. Must satisfy 2^BIN_W > 10^N_DIGITS - 1.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- key_valid  input  1  one-cycle strobe: key_code valid this cycle
- key_code  input  4  0x0-0x9 digit, 0xA enter, 0xB clear, 0xC-0xF ignored
- ack  input  1  downstream has consumed operands; meaningful only while done=1
- numero1_bcd  output  4*N_DIGITS  operand 1, BCD, least-significant digit in [3:0]
- numero2_bcd  output  4*N_DIGITS  operand 2, BCD
- numero1_bin  output  BIN_W  operand 1, binary
- numero2_bin  output  BIN_W  operand 2, binary
- digit_count  output  2  digits accepted into the operand currently being entered
- sel_num2  output  1  0 = entering operand 1, 1 = entering operand 2
- done  output  1  both operands complete and stable

Behaviour:
- Reset, asynchronous on rst=1:
  - FSM goes to S_NUM1.
  - All operand registers, digit_count, sel_num2 and done go to 0.
  - Reset mid-entry discards all partial data.
- FSM states: S_NUM1, S_NUM2, S_DONE. sel_num2=1 in S_NUM2 and S_DONE. done=1 only in S_DONE.
- Key acceptance: a key is processed only on a rising edge with key_valid=1. Results are visible on outputs the following cycle. No combinational path from inputs to outputs.
- Digit key in S_NUM1 or S_NUM2 with digit_count < N_DIGITS, applied to the active operand:
  - BCD = (BCD << 4) | digit.
  - bin = bin*10 + digit, computed at BIN_W bits; cannot overflow given the parameter rule.
  - digit_count increments.
- Digit key with digit_count = N_DIGITS: ignored, no register change.
- Enter (0xA):
  - In S_NUM1: go to S_NUM2 and clear digit_count. Allowed with zero digits; operand 1 stays 0.
  - In S_NUM2: go to S_DONE.
- Clear (0xB) in any state: clear both operands and digit_count, go to S_NUM1.
- In S_DONE:
  - Operands hold constant.
  - Digit, enter and ignored codes have no effect.
  - ack=1 (or clear) clears all operands and goes to S_NUM1. done falls the cycle after ack is sampled.
- ack outside S_DONE: ignored.
- ack and key_valid in the same cycle in S_DONE: ack wins and the key is dropped, including a clear key; the result is identical.
- Codes 0xC-0xF: no effect in any state.
- key_valid=0: key_code is don't-care.

Test Plan:
- Reset: assert rst mid-entry after digits 4,5 -> next cycle all outputs 0, sel_num2=0, done=0; asserted asynchronously without waiting for a clk edge.
- Full entry: keys 1,2,3,A,4,5,A -> numero1_bcd=0x123, numero1_bin=123, numero2_bcd=0x045, numero2_bin=45, done=1 one cycle after second enter.
- Digit overflow: keys 9,9,9,7 in S_NUM1 -> numero1_bcd=0x999, bin=999, digit_count=3; the 7 is ignored.
- Empty operand: keys A,8,A -> numero1=0, numero2_bcd=0x008, numero2_bin=8, done=1.
- Handshake: in S_DONE send key 5 -> operands unchanged. Pulse ack with simultaneous key 3 -> next cycle done=0, all operands 0, digit_count=0 (key dropped).
- Clear and junk: keys 6,0xE,0xB -> 0xE is ignored, clear returns all outputs to 0 in S_NUM1. Gaps of several idle cycles between strobes change nothing.
